// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: two-master, one-slave arbiter for the platform core bus.
// Master 0 is the CPU core, master 1 a DMA/debug engine. Single-cycle start
// pulses are captured into per-master slots, granted round-robin, and exactly
// one bus transaction runs at a time. Ready and read data go back only to the
// master that owns the transaction.
//
// Handshake: every start and ready is a single-cycle pulse. A start is
// accepted when the master has no pending request and does not own the
// in-flight transaction; otherwise it is dropped and the original request
// stands. bus_ready is only honoured while a transaction is in flight.
//
// State visibility: busy is registered alongside state_q and equals
// (state_q == ST_WAIT), so it serves as the FSM state output.
//
// Optional feature: define CORE_BUS_ARB_TIMEOUT_EN to add a WAIT timeout that
// forces a faulted completion (data 0, bus_fault pulse) after TIMEOUT cycles.
module core_bus_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_data_wr,
    input  logic              m0_start,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_data_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_data_wr,
    input  logic              m1_start,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_data_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_data_wr,
    output logic              bus_start,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_data_rd,
`ifdef CORE_BUS_ARB_TIMEOUT_EN
    output logic              bus_fault,
`endif
    output logic              owner,
    output logic              busy
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] slot_addr_q [2];
    logic [ADDR_W-1:0] slot_addr_d [2];
    logic [1:0]        slot_write_q, slot_write_d;
    logic [DATA_W-1:0] slot_data_q [2];
    logic [DATA_W-1:0] slot_data_d [2];
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_write_q, bus_write_d;
    logic [DATA_W-1:0] bus_data_wr_q, bus_data_wr_d;
    logic              bus_start_q, bus_start_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [1:0]        ready_q, ready_d;
    logic [DATA_W-1:0] data_rd_q [2];
    logic [DATA_W-1:0] data_rd_d [2];
    logic              win;

    // Per-master views of the request inputs so capture can loop over masters.
    logic [ADDR_W-1:0] m_addr [2];
    logic [DATA_W-1:0] m_data [2];
    logic [1:0]        m_write;
    logic [1:0]        m_start;

    assign m_addr[0] = m0_addr;
    assign m_addr[1] = m1_addr;
    assign m_data[0] = m0_data_wr;
    assign m_data[1] = m1_data_wr;
    assign m_write   = {m1_write, m0_write};
    assign m_start   = {m1_start, m0_start};

`ifdef CORE_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
`endif

    // Next-state: request capture, round-robin grant and completion handling.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        last_grant_d  = last_grant_q;
        slot_addr_d   = slot_addr_q;
        slot_write_d  = slot_write_q;
        slot_data_d   = slot_data_q;
        bus_addr_d    = bus_addr_q;
        bus_write_d   = bus_write_q;
        bus_data_wr_d = bus_data_wr_q;
        bus_start_d   = 1'b0;
        owner_d       = owner_q;
        busy_d        = busy_q;
        ready_d       = 2'b00;
        data_rd_d     = data_rd_q;
        win           = 1'b0;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        fault_d       = 1'b0;
`endif

        // A start is dropped while its slot is full or its master owns the bus.
        for (int n = 0; n < 2; n++) begin
            if (m_start[n] && !pend_q[n] && !(busy_q && (owner_q == n[0]))) begin
                slot_addr_d[n]  = m_addr[n];
                slot_write_d[n] = m_write[n];
                slot_data_d[n]  = m_data[n];
                pend_d[n]       = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    // Single pending wins outright; a tie goes to the master
                    // that did not win last time.
                    win           = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
                    bus_addr_d    = slot_addr_q[win];
                    bus_write_d   = slot_write_q[win];
                    bus_data_wr_d = slot_data_q[win];
                    bus_start_d   = 1'b1;
                    owner_d       = win;
                    busy_d        = 1'b1;
                    pend_d[win]   = 1'b0;
                    last_grant_d  = win;
                    state_d       = ST_WAIT;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (bus_ready) begin
                    ready_d[owner_q]   = 1'b1;
                    data_rd_d[owner_q] = bus_data_rd;
                    busy_d             = 1'b0;
                    state_d            = ST_IDLE;
                end
`ifdef CORE_BUS_ARB_TIMEOUT_EN
                else if (cnt_q == TO_VAL) begin
                    ready_d[owner_q]   = 1'b1;
                    data_rd_d[owner_q] = '0;
                    fault_d            = 1'b1;
                    busy_d             = 1'b0;
                    state_d            = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards pending requests and any in-flight transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pend_q         <= 2'b00;
            last_grant_q   <= 1'b1;
            slot_addr_q[0] <= '0;
            slot_addr_q[1] <= '0;
            slot_write_q   <= 2'b00;
            slot_data_q[0] <= '0;
            slot_data_q[1] <= '0;
            bus_addr_q     <= '0;
            bus_write_q    <= 1'b0;
            bus_data_wr_q  <= '0;
            bus_start_q    <= 1'b0;
            owner_q        <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 2'b00;
            data_rd_q[0]   <= '0;
            data_rd_q[1]   <= '0;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
            cnt_q          <= '0;
            fault_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            last_grant_q   <= last_grant_d;
            slot_addr_q    <= slot_addr_d;
            slot_write_q   <= slot_write_d;
            slot_data_q    <= slot_data_d;
            bus_addr_q     <= bus_addr_d;
            bus_write_q    <= bus_write_d;
            bus_data_wr_q  <= bus_data_wr_d;
            bus_start_q    <= bus_start_d;
            owner_q        <= owner_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            data_rd_q      <= data_rd_d;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
            cnt_q          <= cnt_d;
            fault_q        <= fault_d;
`endif
        end
    end

    assign bus_addr    = bus_addr_q;
    assign bus_write   = bus_write_q;
    assign bus_data_wr = bus_data_wr_q;
    assign bus_start   = bus_start_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign m0_ready    = ready_q[0];
    assign m1_ready    = ready_q[1];
    assign m0_data_rd  = data_rd_q[0];
    assign m1_data_rd  = data_rd_q[1];
`ifdef CORE_BUS_ARB_TIMEOUT_EN
    assign bus_fault   = fault_q;
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Testbench for core_bus_arbiter: directed steps with a bus-transaction
// scoreboard (expected grants) and a response scoreboard (expected readies).
// Build with CORE_BUS_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_core_bus_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_write, m1_write;
  logic [DW-1:0] m0_data_wr, m1_data_wr;
  logic          m0_start, m1_start;
  logic          m0_ready, m1_ready;
  logic [DW-1:0] m0_data_rd, m1_data_rd;
  logic [AW-1:0] bus_addr;
  logic          bus_write;
  logic [DW-1:0] bus_data_wr;
  logic          bus_start;
  logic          bus_ready;
  logic [DW-1:0] bus_data_rd;
  logic          bus_fault;
  logic          owner;
  logic          busy;

  core_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_write(m0_write), .m0_data_wr(m0_data_wr),
    .m0_start(m0_start), .m0_ready(m0_ready), .m0_data_rd(m0_data_rd),
    .m1_addr(m1_addr), .m1_write(m1_write), .m1_data_wr(m1_data_wr),
    .m1_start(m1_start), .m1_ready(m1_ready), .m1_data_rd(m1_data_rd),
    .bus_addr(bus_addr), .bus_write(bus_write), .bus_data_wr(bus_data_wr),
    .bus_start(bus_start), .bus_ready(bus_ready), .bus_data_rd(bus_data_rd),
`ifdef CORE_BUS_ARB_TIMEOUT_EN
    .bus_fault(bus_fault),
`endif
    .owner(owner), .busy(busy)
  );

`ifndef CORE_BUS_ARB_TIMEOUT_EN
  assign bus_fault = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state: bus entries {owner, write, addr, data_wr}; responses {fault, master, data}
  int            n_checks = 0;
  int            n_err    = 0;
  logic [63:0]   bus_q [$];
  logic [33:0]   rsp_q [$];
  logic          cur_owner = 1'b0;
  logic          prev_busy = 1'b0;
  logic [62:0]   held = '0;
  logic [63:0]   e;
  logic [33:0]   r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // monitor: grants, bus hold while busy, and responses
  always @(negedge clk) begin
    if (bus_start) begin
      chk("start_while_busy", 64'(prev_busy), 64'd0);
      chk("expected_bus_start", 64'(bus_q.size() != 0), 64'd1);
      if (bus_q.size() != 0) begin
        e = bus_q.pop_front();
        chk("bus_txn", {owner, bus_write, bus_addr, bus_data_wr}, e);
        cur_owner = e[63];
      end
      held = {bus_write, bus_addr, bus_data_wr};
    end else if (busy) begin
      chk("bus_hold", 64'({bus_write, bus_addr, bus_data_wr}), 64'(held));
    end
    if (m0_ready || m1_ready) begin
      chk("ready_onehot", 64'(m0_ready & m1_ready), 64'd0);
      chk("expected_ready", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("rsp", 64'({bus_fault, m1_ready, (m1_ready ? m1_data_rd : m0_data_rd)}), 64'(r));
      end
    end
    prev_busy = busy;
  end

  // driver tasks
  task automatic set_m(input logic m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    if (!m) begin
      m0_addr = a; m0_write = w; m0_data_wr = d; m0_start = 1'b1;
    end else begin
      m1_addr = a; m1_write = w; m1_data_wr = d; m1_start = 1'b1;
    end
  endtask

  task automatic req(input logic m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    set_m(m, a, w, d);
    bus_q.push_back({m, w, a, d});
  endtask

  task automatic tick();
    @(negedge clk);
    m0_start = 1'b0;
    m1_start = 1'b0;
  endtask

  task automatic wait_start();
    int t = 0;
    while (!bus_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bus_start", 64'(bus_start), 64'd1);
  endtask

  // slave: ready dly cycles after bus_start, then check ready lands at R+1
  task automatic serve(input int dly, input logic [DW-1:0] d);
    wait_start();
    repeat (dly) @(negedge clk);
    bus_ready   = 1'b1;
    bus_data_rd = d;
    rsp_q.push_back({1'b0, cur_owner, d});
    @(negedge clk);
    bus_ready   = 1'b0;
    bus_data_rd = $urandom;
    chk("ready_latency", 64'({m1_ready, m0_ready}), cur_owner ? 64'd2 : 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_start = 1'b0; m1_start = 1'b0; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({m0_ready, m1_ready, bus_write, bus_start, owner, busy, bus_fault}), 64'd0);
    chk("rst_data_rd", {m0_data_rd, m1_data_rd}, 64'd0);
    chk("rst_bus", 64'({bus_addr, bus_data_wr}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [DW-1:0] d_a, d_b;

  initial begin
    m0_addr = '0; m0_write = 1'b0; m0_data_wr = '0; m0_start = 1'b0;
    m1_addr = '0; m1_write = 1'b0; m1_data_wr = '0; m1_start = 1'b0;
    bus_ready = 1'b0; bus_data_rd = '0;
    do_reset();

    // m0 read at 0x100, slave answers 3 cycles after bus_start
    req(1'b0, AW'('h100), 1'b0, DW'($urandom));
    tick();
    chk("lat_t1", 64'(bus_start), 64'd0);
    @(negedge clk);
    chk("lat_t2", 64'(bus_start), 64'd1);
    serve(3, 32'hDEADBEEF);
    repeat (3) tick();

    // stray ready in IDLE must be ignored
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    repeat (3) tick();
    chk("stray_busy", 64'(busy), 64'd0);

    // simultaneous writes after reset: master 0 wins the first tie
    do_reset();
    req(1'b0, AW'('h10), 1'b1, DW'('h11));
    req(1'b1, AW'('h20), 1'b1, DW'('h22));
    tick();
    d_a = $urandom;
    d_b = $urandom;
    serve(2, d_a);
    serve(2, d_b);
    chk("m0_rd_hold", 64'(m0_data_rd), 64'(d_a));
    repeat (3) tick();

    // continuous contention: restart on each ready, 8 transactions
    req(1'b0, AW'($urandom), 1'($urandom), DW'($urandom));
    req(1'b1, AW'($urandom), 1'($urandom), DW'($urandom));
    tick();
    for (int i = 0; i < 8; i++) begin
      serve($urandom_range(1, 4), DW'($urandom));
      if (i < 6) begin
        req(cur_owner, AW'($urandom), 1'($urandom), DW'($urandom));
        tick();
      end
    end
    repeat (4) tick();
    chk("contention_q_empty", 64'(bus_q.size()), 64'd0);

    // duplicate start while pending: only 0x30 is issued
    req(1'b1, AW'('h30), 1'b0, DW'($urandom));
    tick();
    set_m(1'b1, AW'('h40), 1'b0, DW'($urandom));
    tick();
    serve(2, DW'($urandom));
    repeat (5) tick();
    chk("dup_q_empty", 64'(bus_q.size()), 64'd0);

    // reset mid-WAIT with owner 1 and master 0 pending
    req(1'b1, AW'('h50), 1'b1, DW'($urandom));
    tick();
    wait_start();
    set_m(1'b0, AW'('h60), 1'b0, DW'($urandom));
    tick();
    chk("mid_owner", 64'(owner), 64'd1);
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();
    repeat (10) tick();
    chk("post_rst_idle", 64'({bus_start, busy}), 64'd0);
    req(1'b0, AW'('h70), 1'b0, DW'($urandom));
    tick();
    serve(1, DW'($urandom));
    repeat (3) tick();

    // slave never readies
    req(1'b0, AW'('h80), 1'b0, DW'($urandom));
    tick();
    wait_start();
`ifdef CORE_BUS_ARB_TIMEOUT_EN
    rsp_q.push_back({1'b1, 1'b0, 32'h0});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("to_early", 64'({m0_ready, bus_fault}), 64'd0);
    end
    chk("to_fire", 64'({m0_ready, bus_fault, busy}), 64'b110);
    chk("to_data", 64'(m0_data_rd), 64'd0);
    repeat (3) tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    repeat (3) tick();
    chk("late_ready_idle", 64'({busy, m0_ready, m1_ready}), 64'd0);
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 16 || k == 40) chk("no_to_busy", 64'({busy, m0_ready}), 64'b10);
    end
    do_reset();
`endif

    repeat (3) tick();
    chk("final_bus_q", 64'(bus_q.size()), 64'd0);
    chk("final_rsp_q", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
